// File: rtl/shift_harness_misr.sv
// Purpose: per-channel serial-load shift registers driving a DUT, plus a load/compact run sequencer with MISR signature.
// Latency: dut_src updates on the shifting edge; busy/done/signature are registered and change on the transition edge.
// Backpressure: none; shift_en gates every advance, start is honoured only in IDLE or DONE.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   src_[N_SRC]       serial bit per channel, shifted in at index 0
//   shift_en          advance enable for shift registers, counters and MISR
//   start, run_len    begin a run; run_len (compact cycles) latched on acceptance
//   dut_src           flat register contents, channel c at [c*DEPTH +: DEPTH]
//   dut_dst           DUT result folded into the MISR during COMPACT
//   busy, done        LOAD/COMPACT and DONE state decodes
//   signature         MISR contents
module shift_harness_misr #(
    parameter int              N_SRC = 28,
    parameter int              DEPTH = 28,
    parameter int              N_DST = 33,
    parameter int              SIG_W = 40,
    parameter logic [SIG_W-1:0] POLY = 40'h0000000039,
    parameter int              CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_,
    input  logic                     shift_en,
    input  logic                     start,
    input  logic [CNT_W-1:0]         run_len,
    output logic [N_SRC*DEPTH-1:0]   dut_src,
    input  logic [N_DST-1:0]         dut_dst,
    output logic                     busy,
    output logic                     done,
    output logic [SIG_W-1:0]         signature
);

    // The counter has to reach both DEPTH-1 (load) and run_len-1 (compact).
    localparam int CW = (CNT_W > $clog2(DEPTH)) ? CNT_W : $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPACT,
        S_DONE
    } state_t;

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic [CNT_W-1:0]              run_len_q;
    logic [SIG_W-1:0]              sig_q;
    logic                          busy_q;
    logic                          done_q;
    logic [N_SRC-1:0][DEPTH-1:0]   sr;

    logic                          last_load;
    logic                          last_compact;
    logic [SIG_W-1:0]              sig_next;

    assign last_load    = (cnt == CW'(DEPTH - 1));
    assign last_compact = (cnt == (CW'(run_len_q) - CW'(1)));

    // Galois-style MISR step: shift left, fold the MSB back through POLY, xor in the DUT result.
    assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(dut_dst);

    // Shift registers run in every state, independent of the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_en) begin
            for (int c = 0; c < N_SRC; c++) begin
                sr[c] <= {sr[c][DEPTH-2:0], src_[c]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            run_len_q <= '0;
            sig_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // The start edge may also shift, but it is not counted as a load shift.
                    if (start) begin
                        state     <= S_LOAD;
                        run_len_q <= run_len;
                        cnt       <= '0;
                        sig_q     <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (shift_en) begin
                        if (last_load) begin
                            cnt <= '0;
                            if (run_len_q != '0) begin
                                state <= S_COMPACT;
                            end else begin
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_COMPACT: begin
                    if (shift_en) begin
                        sig_q <= sig_next;
                        if (last_compact) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign dut_src   = sr;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;

endmodule

// File: doc/shift_harness_misr.md
# shift_harness_misr

Parametrised successor to the per-column serial-load harness used in the compressor test benches. It holds N_SRC channels of DEPTH-bit shift registers and drives them to the device under test as one flat bus. It also sequences a run: load, then compact. During the compact phase it folds the DUT's N_DST output bits into a multiple-input signature register (MISR), so a whole run can be checked through a single SIG_W-bit signature rather than by probing every dst pin each cycle.

## Interface
Parameters:
- N_SRC, 28, number of serial input channels (columns)
- DEPTH, 28, bits per channel shift register; must be ≥ 2
- N_DST, 33, width of the DUT result bus folded into the MISR; must be ≤ SIG_W
- SIG_W, 40, signature width
- POLY, 40'h0000000039, MISR feedback polynomial (bit i set = tap at bit i)
- CNT_W, 16, width of the run-length count

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- src_  in  N_SRC  serial bit for each channel; bit c feeds channel c
- shift_en  in  1  advance enable for shift registers, counters and MISR
- start  in  1  begin a run; accepted only in IDLE or DONE
- run_len  in  CNT_W  number of compact cycles; sampled when start is accepted
- dut_src  out  N_SRC*DEPTH  register contents; bits [c*DEPTH +: DEPTH] = channel c
- dut_dst  in  N_DST  combinational result from the DUT
- busy  out  1  high in LOAD or COMPACT
- done  out  1  high in DONE
- signature  out  SIG_W  MISR contents

## Operation
- Shift registers, per channel c, on every edge with shift_en=1 in any state: reg_c <= {reg_c[DEPTH-2:0], src_[c]}. They hold when shift_en=0. The newest bit is at index 0.
- FSM states are IDLE, LOAD, COMPACT and DONE.
- IDLE: on start=1, go to LOAD. Latch run_len, clear shift count cnt to 0 and clear signature to 0.
- LOAD: cnt increments on each shift_en edge. On the edge where cnt==DEPTH-1 and shift_en=1:
  - if the latched run_len != 0, go to COMPACT and set cnt=0;
  - if the latched run_len == 0, go directly to DONE with signature 0.
- COMPACT: on each shift_en edge, signature <= ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extend(dut_dst), and cnt increments. The dut_dst value used is the one present before the edge, so it reflects the pre-shift dut_src. On the edge where cnt==run_len-1, go to DONE.
- DONE: signature and done are held and the registers keep shifting on shift_en. start=1 restarts exactly as it does from IDLE.
- start is ignored in LOAD and COMPACT. run_len changes after acceptance have no effect.
- Edges with shift_en=0 change nothing except the start handling in IDLE/DONE.

## Timing
- Reset, asynchronous: all shift registers 0, so dut_src=0. State IDLE, cnt=0, signature=0, busy=0, done=0. Deassertion takes effect at the next edge.
- Reset asserted mid-run: the run is abandoned immediately and there is no partial signature.
- busy and done are registered state decodes and change on the edge that makes the transition.
- start accepted at edge T: busy=1 after T. The first LOAD shift can occur at T+1 (the start edge itself also shifts if shift_en=1, but is not counted).
- With continuous shift_en: done rises DEPTH+run_len edges after the start edge.
- dut_src reflects a shift on the same edge; there is no extra pipeline stage.
- start and reset together: reset wins.

## Test plan
Configuration N_SRC=2, DEPTH=4, N_DST=3, SIG_W=8, POLY=8'h1D, CNT_W=4 unless stated.
- Reset: assert rst asynchronously mid-cycle → dut_src=8'h00, signature=8'h00, busy=0, done=0 immediately, with no clock edge needed.
- Load: start with run_len=2, then 4 edges with src_=2'b01 and shift_en=1 → dut_src=8'h0F, state COMPACT, busy=1.
- Compact: hold dut_dst=3'b001 for 2 shift_en edges → signature 8'h01 then 8'h03; done=1, busy=0.
- Feedback: force a run with signature reaching 8'h80, then dut_dst=0 on one compact edge → signature=8'h1D. Also check shift_en=0 edges in LOAD/COMPACT leave cnt, signature and dut_src unchanged.
- Boundary and restart:
  - run_len=0: done after exactly 4 load edges with signature=0.
  - start during LOAD is ignored.
  - start in DONE clears signature to 0 and returns busy=1.
  - rst pulse during COMPACT returns IDLE with all zeros.
